// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Holds the forwarding-select and memory-wait FSM enums plus the
// result_src encodings the Execute stage uses to tag its result source.
package hazard_pkg;

    // Forwarding mux select for an Execute-stage operand.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,    // value read from the register file
        FWD_W  = 2'b01,    // result being written back in W
        FWD_M  = 2'b10     // ALU result sitting in M
    } fwd_sel_t;

    // Data-memory wait sequencer.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MEM_WAIT = 2'b01,
        TIMEOUT  = 2'b10
    } mem_fsm_t;

    // result_src encodings of the instruction in Execute.
    localparam logic [2:0] RESULT_SRC_ALU  = 3'b000;
    localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;
    localparam logic [2:0] RESULT_SRC_PC4  = 3'b010;

endpackage

// File: rtl/forward_unit.sv
// Forwarding select for one Execute-stage source operand.
// M has priority over W because it holds the younger result; x0 never
// forwards since it is hard-wired to zero in the register file.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    // Pick the youngest in-flight producer of rs_e, else the register file.
    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd_sel = FWD_M;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing controller for the 5-stage F/D/E/M/W pipeline.
// Produces operand forwarding selects, stage stall/flush enables for
// load-use hazards, taken branches and multi-cycle data-memory accesses,
// and a sticky watchdog flag when a memory access never completes.
// Optional build macro: HAZARD_PERF_CNT_EN adds three saturating 32-bit
// performance counters (load-use stalls, branch flushes, mem-wait cycles).
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter logic [2:0] LOAD_SRC       = RESULT_SRC_LOAD,
    parameter int         TIMEOUT_CYCLES = 64,
    parameter int         CNT_W          = 8
)
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rs1_E,
    input  logic [4:0] rs2_E,
    input  logic [4:0] rd_E,
    input  logic [4:0] rd_M,
    input  logic [4:0] rd_W,
    input  logic       reg_write_M,
    input  logic       reg_write_W,
    input  logic [2:0] result_src_E,
    input  logic       pc_src_E,
    input  logic       mem_access_M,
    input  logic       mem_ready,
    output logic [1:0] forward_a_E,
    output logic [1:0] forward_b_E,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       stall_M,
    output logic       flush_D,
    output logic       flush_E,
    output logic       flush_W,
    output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_lw_stalls,
    output logic [31:0] perf_branch_flushes,
    output logic [31:0] perf_mem_wait_cycles
`endif
);

    // ---------------- forwarding ----------------
    logic [4:0] rs_e_arr [2];
    logic [1:0] fwd_arr  [2];

    assign rs_e_arr[0] = rs1_E;
    assign rs_e_arr[1] = rs2_E;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        forward_unit u_fwd (
            .rs_e        (rs_e_arr[gi]),
            .rd_m        (rd_M),
            .rd_w        (rd_W),
            .reg_write_m (reg_write_M),
            .reg_write_w (reg_write_W),
            .fwd_sel     (fwd_arr[gi])
        );
    end

    assign forward_a_E = fwd_arr[0];
    assign forward_b_E = fwd_arr[1];

    // ---------------- hazard detection ----------------
    mem_fsm_t             state_reg, state_next;
    logic [CNT_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic                 timeout_reg, timeout_next;
    logic                 lw_stall;
    logic                 mem_stall;
    logic                 frozen;

    // Load-use and memory-wait conditions; a timed-out pipe stays frozen.
    always_comb begin
        lw_stall  = (result_src_E == LOAD_SRC) && (rd_E != 5'd0) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));
        mem_stall = ((state_reg == IDLE) && mem_access_M && !mem_ready) ||
                    ((state_reg == MEM_WAIT) && !mem_ready);
        frozen    = mem_stall || (state_reg == TIMEOUT);
    end

    // Memory-wait sequencer next state, wait counter and watchdog flag.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        case (state_reg)
            IDLE: begin
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_next   = TIMEOUT;
                    timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            TIMEOUT: begin
                state_next = TIMEOUT;
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Sequencer state registers, cleared by the synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign mem_timeout = timeout_reg;

    // Stage enables: a memory freeze overrides everything and holds any
    // pending branch/load-use hazard until the access is released.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_W = 1'b0;
        if (frozen) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
            flush_W = 1'b1;
        end else begin
            stall_F = lw_stall;
            stall_D = lw_stall;
            flush_E = lw_stall || pc_src_E;
            flush_D = pc_src_E;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // ---------------- performance counters ----------------
    logic        perf_event   [3];
    logic [31:0] perf_cnt_reg [3];

    assign perf_event[0] = lw_stall && !mem_stall;
    assign perf_event[1] = pc_src_E && !mem_stall;
    assign perf_event[2] = mem_stall;

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        // Saturating event counter, cleared on reset.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                perf_cnt_reg[gi] <= '0;
            end else if (perf_event[gi] && (perf_cnt_reg[gi] != '1)) begin
                perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
            end
        end
    end

    assign perf_lw_stalls       = perf_cnt_reg[0];
    assign perf_branch_flushes  = perf_cnt_reg[1];
    assign perf_mem_wait_cycles = perf_cnt_reg[2];
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller (TIMEOUT_CYCLES = 4).
// A table of single-cycle vectors covers forwarding and hazard precedence;
// hand-written sequences cover memory waits, timeout and reset.
module tb_pipeline_hazard_controller;

    typedef struct packed {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic       rw_m, rw_w;
        logic [2:0] rsrc;
        logic       pc, ma, mr;
    } in_t;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] stall;  // F, D, E, M
        logic [2:0] flush;  // D, E, W
        logic       tmo;
    } out_t;

    typedef struct {
        in_t  vin;
        out_t vexp;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       reg_write_M, reg_write_W;
    logic [2:0] result_src_E;
    logic       pc_src_E, mem_access_M, mem_ready;
    logic [1:0] forward_a_E, forward_b_E;
    logic       stall_F, stall_D, stall_E, stall_M;
    logic       flush_D, flush_E, flush_W, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lw_stalls, perf_branch_flushes, perf_mem_wait_cycles;
`endif

    int   checks   = 0;
    int   failures = 0;
    out_t exp_q [$];
    vec_t vecs  [13];

    always #5 CLK = ~CLK;

    pipeline_hazard_controller #(.TIMEOUT_CYCLES(4)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .rs1_D        (rs1_D),
        .rs2_D        (rs2_D),
        .rs1_E        (rs1_E),
        .rs2_E        (rs2_E),
        .rd_E         (rd_E),
        .rd_M         (rd_M),
        .rd_W         (rd_W),
        .reg_write_M  (reg_write_M),
        .reg_write_W  (reg_write_W),
        .result_src_E (result_src_E),
        .pc_src_E     (pc_src_E),
        .mem_access_M (mem_access_M),
        .mem_ready    (mem_ready),
        .forward_a_E  (forward_a_E),
        .forward_b_E  (forward_b_E),
        .stall_F      (stall_F),
        .stall_D      (stall_D),
        .stall_E      (stall_E),
        .stall_M      (stall_M),
        .flush_D      (flush_D),
        .flush_E      (flush_E),
        .flush_W      (flush_W),
        .mem_timeout  (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_lw_stalls       (perf_lw_stalls),
        .perf_branch_flushes  (perf_branch_flushes),
        .perf_mem_wait_cycles (perf_mem_wait_cycles)
`endif
    );

    function automatic in_t mk(input logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e,
                               input logic [4:0] rd_e, rd_m, rd_w,
                               input logic rw_m, rw_w, input logic [2:0] rsrc,
                               input logic pc, ma, mr);
        in_t v;
        v.rs1_d = rs1_d; v.rs2_d = rs2_d; v.rs1_e = rs1_e; v.rs2_e = rs2_e;
        v.rd_e = rd_e; v.rd_m = rd_m; v.rd_w = rd_w;
        v.rw_m = rw_m; v.rw_w = rw_w; v.rsrc = rsrc;
        v.pc = pc; v.ma = ma; v.mr = mr;
        return v;
    endfunction

    function automatic out_t ex(input logic [1:0] fa, fb, input logic [3:0] st,
                                input logic [2:0] fl, input logic tmo);
        out_t e;
        e.fa = fa; e.fb = fb; e.stall = st; e.flush = fl; e.tmo = tmo;
        return e;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.fa    = forward_a_E;
        o.fb    = forward_b_E;
        o.stall = {stall_F, stall_D, stall_E, stall_M};
        o.flush = {flush_D, flush_E, flush_W};
        o.tmo   = mem_timeout;
        return o;
    endfunction

    task automatic drive(input in_t v);
        rs1_D = v.rs1_d; rs2_D = v.rs2_d; rs1_E = v.rs1_e; rs2_E = v.rs2_e;
        rd_E = v.rd_e; rd_M = v.rd_m; rd_W = v.rd_w;
        reg_write_M = v.rw_m; reg_write_W = v.rw_w; result_src_E = v.rsrc;
        pc_src_E = v.pc; mem_access_M = v.ma; mem_ready = v.mr;
    endtask

    task automatic cmp(input string name, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got fa=%b fb=%b stall=%b flush=%b tmo=%b, want fa=%b fb=%b stall=%b flush=%b tmo=%b",
                     name, got.fa, got.fb, got.stall, got.flush, got.tmo,
                     want.fa, want.fb, want.stall, want.flush, want.tmo);
        end else begin
            $display("ok   %s: fa=%b fb=%b stall=%b flush=%b tmo=%b",
                     name, got.fa, got.fb, got.stall, got.flush, got.tmo);
        end
    endtask

    task automatic cmp32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    // One transaction: drive after the edge, queue the expectation, check mid-cycle.
    task automatic step(input string name, input in_t v, input out_t e);
        out_t want;
        @(posedge CLK);
        #1;
        drive(v);
        exp_q.push_back(e);
        @(negedge CLK);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            want = exp_q.pop_front();
            cmp(name, sample(), want);
        end
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        drive(mk(0,0,0,0,0,0,0,0,0,3'b000,0,0,0));
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        in_t  zero;
        out_t idle;
        in_t  wait_pc;
        in_t  wait_nopc;
        zero      = mk(0,0,0,0,0,0,0,0,0,3'b000,0,0,0);
        idle      = ex(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        wait_pc   = mk(0,0,0,0,0,0,0,0,0,3'b000,1,1,0);
        wait_nopc = mk(0,0,0,0,0,0,0,0,0,3'b000,0,1,0);

        //                 rs1D rs2D rs1E rs2E rdE rdM rdW rwM rwW rsrc  pc ma mr
        vecs[0]  = '{mk(0, 0, 5, 0, 0, 5, 5, 1, 1, 3'b000, 0, 0, 0), ex(2'b10, 2'b00, 4'b0000, 3'b000, 0)};
        vecs[1]  = '{mk(0, 0, 5, 0, 0, 0, 5, 1, 1, 3'b000, 0, 0, 0), ex(2'b01, 2'b00, 4'b0000, 3'b000, 0)};
        vecs[2]  = '{mk(0, 0, 0, 0, 0, 5, 5, 1, 1, 3'b000, 0, 0, 0), ex(2'b00, 2'b00, 4'b0000, 3'b000, 0)};
        vecs[3]  = '{mk(0, 0, 0, 3, 0, 3, 3, 0, 1, 3'b000, 0, 0, 0), ex(2'b00, 2'b01, 4'b0000, 3'b000, 0)};
        vecs[4]  = '{mk(0, 0, 9, 9, 0, 9, 0, 1, 1, 3'b000, 0, 0, 0), ex(2'b10, 2'b10, 4'b0000, 3'b000, 0)};
        vecs[5]  = '{mk(0, 0, 6, 0, 0, 0, 6, 0, 0, 3'b000, 0, 0, 0), ex(2'b00, 2'b00, 4'b0000, 3'b000, 0)};
        vecs[6]  = '{mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 3'b001, 0, 0, 0), ex(2'b00, 2'b00, 4'b1100, 3'b010, 0)};
        vecs[7]  = '{mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0), ex(2'b00, 2'b00, 4'b0000, 3'b000, 0)};
        vecs[8]  = '{mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 3'b000, 0, 0, 0), ex(2'b00, 2'b00, 4'b0000, 3'b000, 0)};
        vecs[9]  = '{mk(4, 0, 0, 0, 4, 0, 0, 0, 0, 3'b001, 0, 0, 0), ex(2'b00, 2'b00, 4'b1100, 3'b010, 0)};
        vecs[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0), ex(2'b00, 2'b00, 4'b0000, 3'b110, 0)};
        vecs[11] = '{mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 3'b001, 1, 0, 0), ex(2'b00, 2'b00, 4'b1100, 3'b110, 0)};
        vecs[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1), ex(2'b00, 2'b00, 4'b0000, 3'b000, 0)};

        RESET = 1'b1;
        drive(zero);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        cmp("reset_outputs", sample(), idle);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        step("after_reset", zero, idle);

        for (int i = 0; i < 13; i++) begin
            step($sformatf("vec%0d", i), vecs[i].vin, vecs[i].vexp);
        end
        step("zero_wait_stays_idle", zero, idle);

        // Three wait cycles with a branch pending, then the ready cycle.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("memwait%0d", i), wait_pc, ex(2'b00, 2'b00, 4'b1111, 3'b001, 0));
        end
        step("mem_ready_release", mk(0,0,0,0,0,0,0,0,0,3'b000,1,1,1),
             ex(2'b00, 2'b00, 4'b0000, 3'b110, 0));
        step("post_release_idle", zero, idle);

        // Reset in the middle of a wait restarts the watchdog count.
        step("pre_reset_wait0", wait_nopc, ex(2'b00, 2'b00, 4'b1111, 3'b001, 0));
        step("pre_reset_wait1", wait_nopc, ex(2'b00, 2'b00, 4'b1111, 3'b001, 0));
        pulse_reset();
        step("reset_mid_wait", zero, idle);

        // Watchdog: stall cycle in IDLE plus four counted wait cycles, then TIMEOUT.
        for (int i = 0; i < 5; i++) begin
            step($sformatf("towait%0d", i), wait_nopc, ex(2'b00, 2'b00, 4'b1111, 3'b001, 0));
        end
        for (int i = 0; i < 3; i++) begin
            step($sformatf("timeout%0d", i), mk(0,7,0,0,7,0,0,0,0,3'b001,1,0,1),
                 ex(2'b00, 2'b00, 4'b1111, 3'b001, 1));
        end
        pulse_reset();
        step("reset_clears_timeout", zero, idle);
        step("idle_after_timeout_reset", vecs[10].vin, vecs[10].vexp);

`ifdef HAZARD_PERF_CNT_EN
        pulse_reset();
        step("perf_lw0", vecs[6].vin, vecs[6].vexp);
        step("perf_lw1", vecs[9].vin, vecs[9].vexp);
        step("perf_br", vecs[10].vin, vecs[10].vexp);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("perf_wait%0d", i), wait_nopc, ex(2'b00, 2'b00, 4'b1111, 3'b001, 0));
        end
        step("perf_ready", mk(0,0,0,0,0,0,0,0,0,3'b000,0,1,1), idle);
        step("perf_idle", zero, idle);
        cmp32("perf_lw_stalls", perf_lw_stalls, 32'd2);
        cmp32("perf_branch_flushes", perf_branch_flushes, 32'd1);
        cmp32("perf_mem_wait_cycles", perf_mem_wait_cycles, 32'd3);
        pulse_reset();
        @(negedge CLK);
        cmp32("perf_lw_reset", perf_lw_stalls, 32'd0);
        cmp32("perf_br_reset", perf_branch_flushes, 32'd0);
        cmp32("perf_wait_reset", perf_mem_wait_cycles, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "time limit");
    end

endmodule
